// File: rtl/requant_pipe_pkg.sv
// Shared types and clamp-bound helpers for the requantization pipeline.
package requant_pipe_pkg;

    localparam int unsigned DEF_OUT_W   = 8;
    localparam int unsigned DEF_MULT_W  = 16;
    localparam int unsigned DEF_SHIFT_W = 6;

    typedef struct packed {
        logic signed [DEF_MULT_W-1:0] mult;
        logic [DEF_SHIFT_W-1:0]       shift;
        logic signed [DEF_OUT_W:0]    zp;
    } qparam_t;

    function automatic int qmax_s(input int unsigned out_w, input logic uns);
        return uns ? (1 << out_w) - 1 : (1 << (out_w - 1)) - 1;
    endfunction

    function automatic int qmin_s(input int unsigned out_w, input logic uns);
        return uns ? 0 : -(1 << (out_w - 1));
    endfunction

endpackage

// File: rtl/requant_pipe_table.sv
// Per-channel {mult, shift, zp} register file: one write port, async read, resets to identity.
module quant_param_table
    import requant_pipe_pkg::*;
#(
    parameter int unsigned NUM_CH  = 16,
    parameter int unsigned MULT_W  = DEF_MULT_W,
    parameter int unsigned SHIFT_W = DEF_SHIFT_W,
    parameter int unsigned ZP_W    = DEF_OUT_W + 1
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [$clog2(NUM_CH)-1:0] wr_idx,
    input  logic signed [MULT_W-1:0]  wr_mult,
    input  logic [SHIFT_W-1:0]        wr_shift,
    input  logic signed [ZP_W-1:0]    wr_zp,
    input  logic [$clog2(NUM_CH)-1:0] rd_idx,
    output logic signed [MULT_W-1:0]  rd_mult,
    output logic [SHIFT_W-1:0]        rd_shift,
    output logic signed [ZP_W-1:0]    rd_zp
);

    logic signed [MULT_W-1:0] mult_q  [NUM_CH];
    logic [SHIFT_W-1:0]       shift_q [NUM_CH];
    logic signed [ZP_W-1:0]   zp_q    [NUM_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_q  <= '{default: MULT_W'(1)};
            shift_q <= '{default: '0};
            zp_q    <= '{default: '0};
        end else if (wr_en) begin
            mult_q[wr_idx]  <= wr_mult;
            shift_q[wr_idx] <= wr_shift;
            zp_q[wr_idx]    <= wr_zp;
        end
    end

    assign rd_mult  = mult_q[rd_idx];
    assign rd_shift = shift_q[rd_idx];
    assign rd_zp    = zp_q[rd_idx];

endmodule

// File: rtl/requant_pipe.sv
// Requantization pipe: multiply, rounding right shift, zero-point add, clamp, with stall-capable handshake.
module requant_pipe
    import requant_pipe_pkg::*;
#(
    parameter int unsigned IN_W     = 32,
    parameter int unsigned OUT_W    = DEF_OUT_W,
    parameter int unsigned MULT_W   = DEF_MULT_W,
    parameter int unsigned SHIFT_W  = DEF_SHIFT_W,
    parameter int unsigned NUM_CH   = 16,
    parameter int unsigned SATCNT_W = 16
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic signed [MULT_W-1:0]  cfg_mult,
    input  logic [SHIFT_W-1:0]        cfg_shift,
    input  logic signed [OUT_W:0]     cfg_zp,
    input  logic [$clog2(NUM_CH)-1:0] num_ch_m1,
    input  logic                      per_channel,
    input  logic                      auto_ch,
    input  logic                      out_unsigned,
    input  logic                      relu_en,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [IN_W-1:0]    in_data,
    input  logic [$clog2(NUM_CH)-1:0] in_ch,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic                      out_last,
    output logic                      out_sat,
    output logic [SATCNT_W-1:0]       sat_count,
    input  logic                      sat_clr
);

    localparam int unsigned CH_W = $clog2(NUM_CH);
    localparam int unsigned P_W  = IN_W + MULT_W;
    localparam int unsigned V_W  = P_W + 1;

    logic [CH_W-1:0]          ch_cnt, rd_ch;
    logic signed [MULT_W-1:0] tbl_mult;
    logic [SHIFT_W-1:0]       tbl_shift;
    logic signed [OUT_W:0]    tbl_zp;
    logic                     accept, s2_adv, s3_adv;

    logic                     s1_valid, s1_uns, s1_relu, s1_last;
    logic signed [P_W-1:0]    s1_prod, prod_c;
    logic [SHIFT_W-1:0]       s1_shift;
    logic signed [OUT_W:0]    s1_zp;

    logic                     s2_valid, s2_uns, s2_relu, s2_last;
    logic signed [V_W-1:0]    s2_sh, rnd_c, sh_c;
    logic signed [OUT_W:0]    s2_zp;

    logic signed [V_W-1:0]    v_c, zp_ext, lo_c, hi_c, rmin_c, clamp_c;
    logic                     sat_c;

    assign s3_adv   = !out_valid || out_ready;
    assign s2_adv   = !s2_valid || s3_adv;
    assign in_ready = !s1_valid || s2_adv;
    assign accept   = in_valid && in_ready;
    assign rd_ch    = !per_channel ? '0 : (auto_ch ? ch_cnt : in_ch);

    quant_param_table #(
        .NUM_CH  (NUM_CH),
        .MULT_W  (MULT_W),
        .SHIFT_W (SHIFT_W),
        .ZP_W    (OUT_W + 1)
    ) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (cfg_we),
        .wr_idx   (cfg_ch),
        .wr_mult  (cfg_mult),
        .wr_shift (cfg_shift),
        .wr_zp    (cfg_zp),
        .rd_idx   (rd_ch),
        .rd_mult  (tbl_mult),
        .rd_shift (tbl_shift),
        .rd_zp    (tbl_zp)
    );

    // in_last clears the counter even when it coincides with the wrap point
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ch_cnt <= '0;
        else if (accept) begin
            if (in_last || ch_cnt == num_ch_m1)
                ch_cnt <= '0;
            else
                ch_cnt <= ch_cnt + CH_W'(1);
        end
    end

    assign prod_c = P_W'(in_data) * P_W'(tbl_mult);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_shift <= '0;
            s1_zp    <= '0;
            s1_uns   <= 1'b0;
            s1_relu  <= 1'b0;
            s1_last  <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= accept;
            if (accept) begin
                s1_prod  <= prod_c;
                s1_shift <= tbl_shift;
                s1_zp    <= tbl_zp;
                s1_uns   <= out_unsigned;
                s1_relu  <= relu_en;
                s1_last  <= in_last;
            end
        end
    end

    // One extra bit of headroom keeps the rounding add from overflowing
    always_comb begin
        rnd_c = '0;
        sh_c  = V_W'(s1_prod);
        if (s1_shift != '0) begin
            rnd_c = V_W'(1) << (s1_shift - SHIFT_W'(1));
            sh_c  = (V_W'(s1_prod) + rnd_c) >>> s1_shift;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sh    <= '0;
            s2_zp    <= '0;
            s2_uns   <= 1'b0;
            s2_relu  <= 1'b0;
            s2_last  <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sh   <= sh_c;
                s2_zp   <= s1_zp;
                s2_uns  <= s1_uns;
                s2_relu <= s1_relu;
                s2_last <= s1_last;
            end
        end
    end

    always_comb begin
        zp_ext  = V_W'(s2_zp);
        v_c     = s2_sh + zp_ext;
        hi_c    = V_W'(qmax_s(OUT_W, s2_uns));
        rmin_c  = V_W'(qmin_s(OUT_W, s2_uns));
        lo_c    = (s2_relu && zp_ext > rmin_c) ? zp_ext : rmin_c;
        sat_c   = (v_c < lo_c) || (v_c > hi_c);
        clamp_c = v_c;
        if (v_c < lo_c)
            clamp_c = lo_c;
        else if (v_c > hi_c)
            clamp_c = hi_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
        end else if (s3_adv) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_data <= clamp_c[OUT_W-1:0];
                out_last <= s2_last;
                out_sat  <= sat_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_count <= '0;
        else if (sat_clr)
            sat_count <= '0;
        else if (out_valid && out_ready && out_sat && sat_count != '1)
            sat_count <= sat_count + SATCNT_W'(1);
    end

endmodule

// File: doc/requant_pipe.md
# requant_pipe

Parametrised INT requantization pipeline: successor to the scalar INT8 quantizer. It takes wide signed accumulator values from the PE array and applies a per-channel integer multiplier, a variable right shift with rounding, and a zero-point. The result is saturated to a configurable signed or unsigned output width, with optional fused ReLU. The block sits between the accumulator drain and the activation writeback buffer. It uses a valid/ready stall-capable pipeline, a writable per-channel parameter table, automatic channel sequencing, and saturation statistics.

## Interface
- IN_W, 32, accumulator input width (signed)
- OUT_W, 8, output width, 2..16
- MULT_W, 16, per-channel multiplier width (signed)
- SHIFT_W, 6, shift field width; shift values 0..IN_W+MULT_W-2
- NUM_CH, 16, parameter table depth (power of 2)
- SATCNT_W, 16, saturation counter width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  parameter table write strobe
- cfg_ch  in  $clog2(NUM_CH)  table write index
- cfg_mult  in  MULT_W  multiplier to write (signed)
- cfg_shift  in  SHIFT_W  right-shift to write (unsigned)
- cfg_zp  in  OUT_W+1  zero-point to write (signed)
- num_ch_m1  in  $clog2(NUM_CH)  active channel count minus 1 (auto mode wrap)
- per_channel  in  1  0 = use table entry 0 for all beats, 1 = per-channel
- auto_ch  in  1  1 = internal channel counter, 0 = use in_ch
- out_unsigned  in  1  1 = clamp to [0, 2^OUT_W-1], 0 = [-2^(OUT_W-1), 2^(OUT_W-1)-1]
- relu_en  in  1  lower clamp raised to max(zp, range min)
- in_valid / in_ready  in / out  1  input handshake
- in_data  in  IN_W  accumulator value
- in_ch  in  $clog2(NUM_CH)  explicit channel (auto_ch=0)
- in_last  in  1  last beat of tensor row; clears auto counter
- out_valid / out_ready  out / in  1  output handshake
- out_data  out  OUT_W  quantized value (raw bits; interpretation per out_unsigned)
- out_last  out  1  in_last delayed with data
- out_sat  out  1  this beat was clamped
- sat_count  out  SATCNT_W  saturating count of clamped beats
- sat_clr  in  1  synchronous clear of sat_count

## Operation
- Beat accepted when in_valid && in_ready. Parameters {mult, shift, zp} are read from the table at acceptance and carried down the pipe. Mode inputs are sampled at acceptance.
- Channel select: per_channel=0 → entry 0. Otherwise auto_ch ? ch_cnt : in_ch.
- ch_cnt increments per accepted beat. It wraps to 0 after reaching num_ch_m1, and clears to 0 after an accepted beat with in_last=1 (the last beat takes priority over wrap).
- S1: prod = in_data * mult, full IN_W+MULT_W signed.
- S2: shift==0 → sh = prod. Otherwise sh = (prod + 2^(shift-1)) >>> shift (round half toward +inf).
- S3: v = sh + zp, sign-extended; no intermediate overflow permitted. Clamp to [lo, hi] per mode:
  - relu_en: lo = max(zp, range min).
  - out_sat = (v<lo)||(v>hi).
  - out_data = clamped[OUT_W-1:0].
- sat_count increments on each output handshake with out_sat=1. It saturates at all-ones. sat_clr wins over a simultaneous increment.
- Table write: a cfg_we beat in the same cycle as an acceptance reading the same entry gives the acceptance the OLD value. The new value is visible from the next cycle.

## Timing
- 3-stage pipe. Latency is 3 cycles from acceptance to out_valid when unstalled; throughput is 1 beat/cycle.
- Stage n advances when it is empty or stage n+1 advances. in_ready = !s1_valid || s1_advance. No combinational in_valid→in_ready path.
- out_valid/out_data/out_last/out_sat are held stable while out_valid && !out_ready.
- Reset values:
  - out_valid=0, out_data=0, out_last=0, out_sat=0
  - sat_count=0, ch_cnt=0
  - all table entries: mult=1, shift=0, zp=0 (identity+clamp)
  - in_ready=1 from the first cycle after reset release
- Reset mid-operation drops in-flight beats; no partial output.

## Structure
- npu_pkg additions:
  - typedef qparam_t {mult, shift, zp} (widths from package defaults)
  - localparams QMAX_S/QMIN_S helper functions for clamp bounds
- Sub-module quant_param_table: NUM_CH x qparam_t register file, 1 write port, 1 async read port, reset to identity.
- Top: ch counter, 3-stage datapath, clamp, and stat counter.

## Test plan
- Identity default: after reset, in_data=-200, 57, 300 (OUT_W=8, signed) → out_data -128 (sat), 57, 127 (sat); sat_count=2.
- Rounding: mult=3, shift=2, zp=5; in_data=5 → (15+2)>>>2=4, +5 → 9; in_data=-5 → (-15+2)>>>2=-4, +5 → 1.
- Per-channel auto: num_ch_m1=2, entries zp=0,10,20 (mult=1, shift=0), six beats of 0 with in_last on beat 4 → outputs 0,10,20,0,0,10.
- Unsigned+ReLU: out_unsigned=1, relu_en=1, zp=128, in_data=-50 → 128 with out_sat=1; in_data=200 → 255 with out_sat=1.
- Backpressure: 10-beat stream, out_ready toggled 1/0 every cycle → all 10 beats emitted in order, no loss or duplication, outputs stable while stalled, in_ready deasserts when the pipe is full.
- Config race: cfg_we to ch3 (zp 0→7) in the same cycle as a ch3 acceptance → that beat uses zp=0, the next beat uses zp=7. Assert rst_n mid-stream → out_valid=0 next cycle, sat_count=0.
